// File: rtl/ooo_hazard_ctrl_n_if.sv
// Hazard-control bus for ooo_hazard_ctrl_n.
// Carries the decode/issue/commit/fetch status inputs and the stall, flush
// and redirect outputs. master = environment (drives status), slave = the
// hazard controller.
interface ooo_hazard_ctrl_n_if #(
  parameter int NUM_FU = 4,
  parameter int WORD_W = 32
);
  logic [NUM_FU-1:0] fu_req;
  logic [NUM_FU-1:0] fu_busy;
  logic              data_hazard;
  logic              rob_full;
  logic              i_mem_busy;
  logic              d_mem_busy;
  logic              mispredict;
  logic [WORD_W-1:0] brj_addr;
  logic              exception;
  logic [WORD_W-1:0] epc;
  logic              intr;

  logic [NUM_FU-1:0] stall_fu;
  logic              stall_de;
  logic              pc_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_comm_flush;
  logic [1:0]        npc_sel;
  logic [WORD_W-1:0] redirect_pc;
  logic              intr_taken;
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output fu_req, fu_busy, data_hazard, rob_full, i_mem_busy, d_mem_busy,
           mispredict, brj_addr, exception, epc, intr,
    input  stall_fu, stall_de, pc_en, if_id_flush, id_ex_flush, ex_comm_flush,
           npc_sel, redirect_pc, intr_taken, stall_cnt, flush_cnt
  );

  modport slave (
    input  fu_req, fu_busy, data_hazard, rob_full, i_mem_busy, d_mem_busy,
           mispredict, brj_addr, exception, epc, intr,
    output stall_fu, stall_de, pc_en, if_id_flush, id_ex_flush, ex_comm_flush,
           npc_sel, redirect_pc, intr_taken, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ooo_hazard_ctrl_n.sv
// ooo_hazard_ctrl_n: central hazard/flush controller for NUM_FU scalar FUs.
// Generates per-FU issue stalls, decode stall and fetch enable; sequences
// recovery RUN -> (DRAIN) -> FLUSH x FLUSH_HOLD -> REDIRECT -> RUN.
// Commit exceptions take priority over (and preempt) mispredict recovery.
// Ports: CLK, RST (sync, active-high), hz (ooo_hazard_ctrl_n_if.slave).
// Optional: define OOO_HAZARD_PERF_EN to build the saturating stall_cnt /
// flush_cnt performance counters; otherwise both read as 0.

// Per-FU stall cell: request/busy conflict, or forced during recovery.
module ooo_hazard_fu_lane (
  input  logic req,
  input  logic busy,
  input  logic force_stall,
  output logic stall
);
  assign stall = force_stall | (req & busy);
endmodule

module ooo_hazard_ctrl_n #(
  parameter int NUM_FU     = 4,
  parameter int FLUSH_HOLD = 2,
  parameter int WORD_W     = 32
) (
  input logic                CLK,
  input logic                RST,
  ooo_hazard_ctrl_n_if.slave hz
);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD - 1);

  state_t            state, state_nx;
  logic              kind_priv, kind_priv_nx;
  logic [3:0]        hold, hold_nx;
  logic [WORD_W-1:0] rpc, rpc_nx;

  logic              force_stall;
  logic [NUM_FU-1:0] lane_stall;
  logic              stall_de_c, pc_en_c, fl_front_c, fl_rob_c, intr_tk_c;
  logic [1:0]        npc_sel_c;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
    ooo_hazard_fu_lane u_lane (
      .req        (hz.fu_req[i]),
      .busy       (hz.fu_busy[i]),
      .force_stall(force_stall),
      .stall      (lane_stall[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      kind_priv <= 1'b0;
      hold      <= '0;
      rpc       <= '0;
    end else begin
      state     <= state_nx;
      kind_priv <= kind_priv_nx;
      hold      <= hold_nx;
      rpc       <= rpc_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    kind_priv_nx = kind_priv;
    hold_nx      = hold;
    rpc_nx       = rpc;
    force_stall  = 1'b1;
    stall_de_c   = 1'b1;
    pc_en_c      = 1'b0;
    fl_front_c   = 1'b0;
    fl_rob_c     = 1'b0;
    npc_sel_c    = 2'd0;
    intr_tk_c    = 1'b0;
    case (state)
      S_RUN: begin
        force_stall = 1'b0;
        stall_de_c  = (|lane_stall) | hz.data_hazard | hz.rob_full;
        pc_en_c     = ~stall_de_c & ~hz.i_mem_busy;
        if (hz.exception) begin
          rpc_nx = hz.epc;  kind_priv_nx = 1'b1;  state_nx = S_DRAIN;
        end else if (hz.mispredict) begin
          rpc_nx = hz.brj_addr;  kind_priv_nx = 1'b0;
          state_nx = S_FLUSH;  hold_nx = HOLD_INIT;
        end else if (hz.intr) begin
          intr_tk_c = 1'b1;
          rpc_nx = hz.epc;  kind_priv_nx = 1'b1;  state_nx = S_DRAIN;
        end
      end
      // Wait for outstanding data-memory traffic before flushing the ROB.
      S_DRAIN: begin
        if (!hz.d_mem_busy) begin
          state_nx = S_FLUSH;  hold_nx = HOLD_INIT;
        end
      end
      S_FLUSH: begin
        fl_front_c = 1'b1;
        fl_rob_c   = kind_priv;
        if (hz.exception && !kind_priv) begin
          // Older commit fault overrides the younger mispredict recovery.
          rpc_nx = hz.epc;  kind_priv_nx = 1'b1;  state_nx = S_DRAIN;
        end else if (hold == 4'd0) begin
          state_nx = S_REDIRECT;
        end else begin
          hold_nx = hold - 4'd1;
        end
      end
      default: begin // S_REDIRECT
        pc_en_c   = 1'b1;
        npc_sel_c = kind_priv ? 2'd2 : 2'd1;
        if (hz.exception && !kind_priv) begin
          rpc_nx = hz.epc;  kind_priv_nx = 1'b1;  state_nx = S_DRAIN;
        end else begin
          state_nx = S_RUN;
        end
      end
    endcase
  end

  // Reset holds every output low, including the combinational RUN terms.
  assign hz.stall_fu      = RST ? '0 : lane_stall;
  assign hz.stall_de      = ~RST & stall_de_c;
  assign hz.pc_en         = ~RST & pc_en_c;
  assign hz.if_id_flush   = ~RST & fl_front_c;
  assign hz.id_ex_flush   = ~RST & fl_front_c;
  assign hz.ex_comm_flush = ~RST & fl_rob_c;
  assign hz.npc_sel       = RST ? 2'd0 : npc_sel_c;
  assign hz.redirect_pc   = RST ? '0 : rpc;
  assign hz.intr_taken    = ~RST & intr_tk_c;

`ifdef OOO_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state == S_RUN && stall_de_c && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state == S_REDIRECT && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_ooo_hazard_ctrl_n.sv
module tb_ooo_hazard_ctrl_n;
  logic CLK = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_err = 0;

  ooo_hazard_ctrl_n_if #(.NUM_FU(4), .WORD_W(32)) bus ();

  ooo_hazard_ctrl_n #(.NUM_FU(4), .FLUSH_HOLD(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .hz(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.fu_req = '0; bus.fu_busy = '0; bus.data_hazard = 0; bus.rob_full = 0;
    bus.i_mem_busy = 0; bus.d_mem_busy = 0; bus.mispredict = 0;
    bus.exception = 0; bus.intr = 0;
  endtask

  // Check one FLUSH cycle: front flushes high, rob flush as given, all stalls.
  task automatic chk_flush(input string tag, input logic rob);
    chk({tag, "_ifid"}, 64'(bus.if_id_flush), 64'd1);
    chk({tag, "_idex"}, 64'(bus.id_ex_flush), 64'd1);
    chk({tag, "_exc"}, 64'(bus.ex_comm_flush), 64'(rob));
    chk({tag, "_pc"}, 64'(bus.pc_en), 64'd0);
    chk({tag, "_sfu"}, 64'(bus.stall_fu), 64'hF);
  endtask

  task automatic chk_drain(input string tag);
    chk({tag, "_pc"}, 64'(bus.pc_en), 64'd0);
    chk({tag, "_sde"}, 64'(bus.stall_de), 64'd1);
    chk({tag, "_sfu"}, 64'(bus.stall_fu), 64'hF);
    chk({tag, "_ifid"}, 64'(bus.if_id_flush), 64'd0);
  endtask

  task automatic chk_redir(input string tag, input logic [1:0] sel, input logic [31:0] pc);
    chk({tag, "_pc"}, 64'(bus.pc_en), 64'd1);
    chk({tag, "_sel"}, 64'(bus.npc_sel), 64'(sel));
    chk({tag, "_rpc"}, 64'(bus.redirect_pc), 64'(pc));
    chk({tag, "_ifid"}, 64'(bus.if_id_flush), 64'd0);
    chk({tag, "_sde"}, 64'(bus.stall_de), 64'd1);
  endtask

  initial begin
    clr();
    bus.brj_addr = '0; bus.epc = '0;

    // Reset with a mispredict held: must be ignored, all outputs low.
    RST = 1; bus.mispredict = 1;
    tick(); tick();
    chk("rst_sfu", 64'(bus.stall_fu), 64'd0);
    chk("rst_sde", 64'(bus.stall_de), 64'd0);
    chk("rst_pc", 64'(bus.pc_en), 64'd0);
    chk("rst_fl", 64'({bus.if_id_flush, bus.id_ex_flush, bus.ex_comm_flush}), 64'd0);
    chk("rst_sel", 64'(bus.npc_sel), 64'd0);
    chk("rst_rpc", 64'(bus.redirect_pc), 64'd0);
    chk("rst_itk", 64'(bus.intr_taken), 64'd0);
    RST = 0; bus.mispredict = 0;
    settle();
    chk("run_pc", 64'(bus.pc_en), 64'd1);
    tick();
    chk("run2_pc", 64'(bus.pc_en), 64'd1);
    chk("run2_fl", 64'(bus.if_id_flush), 64'd0);

    // Five stalled RUN cycles.
    bus.fu_req = 4'b0100; bus.fu_busy = 4'b0110; settle();
    chk("fu_sfu", 64'(bus.stall_fu), 64'h4);
    chk("fu_sde", 64'(bus.stall_de), 64'd1);
    chk("fu_pc", 64'(bus.pc_en), 64'd0);
    tick();
    bus.fu_req = 4'b1011; bus.fu_busy = 4'b1110; settle();
    chk("nh_sfu", 64'(bus.stall_fu), 64'hA);
    chk("nh_sde", 64'(bus.stall_de), 64'd1);
    tick();
    clr(); bus.data_hazard = 1; settle();
    chk("dh_sfu", 64'(bus.stall_fu), 64'd0);
    chk("dh_sde", 64'(bus.stall_de), 64'd1);
    tick();
    clr(); bus.rob_full = 1; settle();
    chk("rf_sde", 64'(bus.stall_de), 64'd1);
    tick();
    clr(); bus.fu_req = 4'b0001; bus.fu_busy = 4'b0001; settle();
    chk("f0_sfu", 64'(bus.stall_fu), 64'h1);
    tick();
    clr(); bus.i_mem_busy = 1; settle();
    chk("im_sde", 64'(bus.stall_de), 64'd0);
    chk("im_pc", 64'(bus.pc_en), 64'd0);
    tick();
    clr(); settle();
    chk("free_pc", 64'(bus.pc_en), 64'd1);

    // Mispredict: 2 flush cycles (no ROB flush), then redirect to brj_addr.
    bus.mispredict = 1; bus.brj_addr = 32'h0000_1040; settle();
    chk("mp_run_pc", 64'(bus.pc_en), 64'd1);
    tick(); bus.mispredict = 0; settle();
    chk_flush("mp_f1", 1'b0);
    tick(); chk_flush("mp_f2", 1'b0);
    tick(); chk_redir("mp_rd", 2'd1, 32'h0000_1040);
    tick();
    chk("mp_back_sel", 64'(bus.npc_sel), 64'd0);
    chk("mp_back_pc", 64'(bus.pc_en), 64'd1);

    // Exception with 3 drain cycles.
    bus.d_mem_busy = 1; bus.exception = 1; bus.epc = 32'h8000_0100;
    tick(); bus.exception = 0; settle();
    chk_drain("ex_d1");
    tick(); chk_drain("ex_d2");
    tick(); chk_drain("ex_d3");
    bus.d_mem_busy = 0;
    tick(); chk_flush("ex_f1", 1'b1);
    tick(); chk_flush("ex_f2", 1'b1);
    tick(); chk_redir("ex_rd", 2'd2, 32'h8000_0100);
`ifdef OOO_HAZARD_PERF_EN
    chk("perf_mid_fc", 64'(bus.flush_cnt), 64'd1);
`endif
    tick();
    chk("ex_back_pc", 64'(bus.pc_en), 64'd1);

    // Exception preempts a mispredict recovery in its first FLUSH cycle.
    bus.mispredict = 1; bus.brj_addr = 32'h0000_2000;
    tick(); bus.mispredict = 0;
    bus.exception = 1; bus.epc = 32'h9000_0000; settle();
    chk_flush("pe_f1", 1'b0);
    tick(); bus.exception = 0; settle();
    chk_drain("pe_d1");
    tick(); chk_flush("pe_f2", 1'b1);
    tick(); chk_flush("pe_f3", 1'b1);
    tick(); chk_redir("pe_rd", 2'd2, 32'h9000_0000);
    tick();

    // Same-cycle exception + mispredict + intr: exception wins, no intr_taken.
    bus.exception = 1; bus.mispredict = 1; bus.intr = 1;
    bus.epc = 32'hA000_0000; bus.brj_addr = 32'h0000_3000; settle();
    chk("pr_itk", 64'(bus.intr_taken), 64'd0);
    tick(); clr(); settle();
    chk_drain("pr_d1");
    tick(); chk_flush("pr_f1", 1'b1);
    tick(); chk_flush("pr_f2", 1'b1);
    tick(); chk_redir("pr_rd", 2'd2, 32'hA000_0000);
    tick();

    // Interrupt alone; an exception during the PRIV flush is ignored.
    bus.intr = 1; bus.epc = 32'hB000_0000; settle();
    chk("in_itk", 64'(bus.intr_taken), 64'd1);
    tick(); bus.intr = 0; settle();
    chk("in_itk_off", 64'(bus.intr_taken), 64'd0);
    chk_drain("in_d1");
    tick();
    bus.exception = 1; bus.epc = 32'h0000_00C0; settle();
    chk_flush("in_f1", 1'b1);
    tick(); bus.exception = 0; bus.epc = 32'hB000_0000; settle();
    chk_flush("in_f2", 1'b1);
    tick(); chk_redir("in_rd", 2'd2, 32'hB000_0000);
    tick();
    chk("in_back_pc", 64'(bus.pc_en), 64'd1);

`ifdef OOO_HAZARD_PERF_EN
    chk("perf_sc", 64'(bus.stall_cnt), 64'd5);
    chk("perf_fc", 64'(bus.flush_cnt), 64'd5);
`else
    chk("perf_sc_off", 64'(bus.stall_cnt), 64'd0);
    chk("perf_fc_off", 64'(bus.flush_cnt), 64'd0);
`endif

    // Reset in the middle of a recovery abandons it.
    bus.mispredict = 1; bus.brj_addr = 32'h0000_4000;
    tick(); bus.mispredict = 0; settle();
    chk("mr_f1", 64'(bus.if_id_flush), 64'd1);
    RST = 1; settle();
    chk("mr_rst_fl", 64'(bus.if_id_flush), 64'd0);
    tick(); RST = 0; settle();
    chk("mr_run_pc", 64'(bus.pc_en), 64'd1);
    chk("mr_run_fl", 64'(bus.if_id_flush), 64'd0);
    chk("mr_rpc", 64'(bus.redirect_pc), 64'd0);
    chk("mr_sc", 64'(bus.stall_cnt), 64'd0);
    tick();
    chk("mr_run2_pc", 64'(bus.pc_en), 64'd1);
    chk("mr_run2_sel", 64'(bus.npc_sel), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ooo_hazard_ctrl_n.md
Name: ooo_hazard_ctrl_n

Overview:
Parametrised successor to the out-of-order hazard control: one central unit that generates per-functional-unit stalls, decode/fetch stalls and sequenced flush/redirect for NUM_FU scalar functional units. It sits between decode, the FU issue ports, commit (ROB) and fetch. Unlike the previous fixed four-unit combinational scheme, it runs an explicit flush FSM (drain, timed flush, redirect) with commit-exception priority over in-flight mispredict recovery.

Parameters:
NUM_FU, 4, number of scalar functional units (index 0..NUM_FU-1); range 1..16
FLUSH_HOLD, 2, cycles flush outputs stay asserted per recovery; range 1..15
WORD_W, 32, PC/address width

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
fu_req  in  NUM_FU  one-hot FU target of the instruction in decode (all-zero = none)
fu_busy  in  NUM_FU  per-FU busy
data_hazard  in  1  operand hazard at decode
rob_full  in  1  ROB cannot accept
i_mem_busy  in  1  fetch memory busy
d_mem_busy  in  1  data memory transaction outstanding
mispredict  in  1  execute branch/jump resolved wrong (1-cycle pulse)
brj_addr  in  WORD_W  correct branch/jump target
exception  in  1  commit reports exception (1-cycle pulse)
epc  in  WORD_W  trap vector from commit/CSR
intr  in  1  pending interrupt (level)
stall_fu  out  NUM_FU  per-FU issue stall
stall_de  out  1  decode stall
pc_en  out  1  fetch PC update enable
if_id_flush  out  1  flush fetch/decode latch
id_ex_flush  out  1  flush decode/issue latch
ex_comm_flush  out  1  flush execute-to-commit (ROB) state
npc_sel  out  2  0=sequential, 1=brj_addr, 2=priv_pc
redirect_pc  out  WORD_W  latched redirect target
intr_taken  out  1  1-cycle pulse when an interrupt is accepted
stall_cnt  out  32  decode-stall cycle count (optional feature)
flush_cnt  out  16  completed recovery count (optional feature)

Behaviour:
- Reset (RST high at posedge): state=RUN, all outputs 0, redirect_pc=0, hold counter=0; valid mid-recovery, abandons it.
- States: RUN, DRAIN, FLUSH, REDIRECT. Internal flag kind (BR or PRIV) and 4-bit hold counter.
- RUN combinational: stall_fu[i]=fu_req[i]&fu_busy[i]; stall_de=|stall_fu | data_hazard | rob_full; pc_en=~stall_de & ~i_mem_busy; npc_sel=0; flushes 0.
- Event priority in RUN, same cycle: exception > mispredict > intr.
  - exception: latch epc, kind=PRIV, go DRAIN.
  - mispredict: latch brj_addr, kind=BR, go FLUSH, counter=FLUSH_HOLD-1.
  - intr (no exception/mispredict): intr_taken=1 that cycle, latch epc, kind=PRIV, go DRAIN.
- DRAIN: pc_en=0, stall_de=1, stall_fu all 1. Stay while d_mem_busy; when low go FLUSH, counter=FLUSH_HOLD-1.
- FLUSH: if_id_flush=id_ex_flush=1; ex_comm_flush=1 only if kind=PRIV. pc_en=0, all stalls 1. Decrement counter each cycle; at 0 go REDIRECT. Exactly FLUSH_HOLD cycles.
- REDIRECT, 1 cycle: pc_en=1, npc_sel=1 (BR) or 2 (PRIV), redirect_pc valid, stalls 1, flushes 0; then RUN.
- Exception during FLUSH/REDIRECT with kind=BR: preempts. Latch epc, kind=PRIV, go DRAIN. The older commit fault wins.
- mispredict/intr outside RUN: ignored. The flushed path makes the mispredict stale. intr is level, so it is retaken later.
- Exception during DRAIN or kind=PRIV FLUSH/REDIRECT: ignored.
- Minimum recovery latency with d_mem_busy low: exception to redirect = 1 (DRAIN) + FLUSH_HOLD + 1 cycles. Mispredict = FLUSH_HOLD + 1.
- fu_req not one-hot: stall computed bitwise, no error.

Optional Feature:
OOO_HAZARD_PERF_EN
- Defined: stall_cnt increments each RUN cycle with stall_de=1, saturating at 32'hFFFF_FFFF. flush_cnt increments on each REDIRECT, saturating at 16'hFFFF. Both clear on RST.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset: RST=1 two cycles with mispredict=1 -> state RUN, all outputs 0, redirect_pc=0.
- FU stall: NUM_FU=4, fu_req=4'b0100, fu_busy=4'b0110 -> stall_fu=4'b0100, stall_de=1, pc_en=0. fu_busy=0 -> pc_en=1 next cycle.
- Mispredict: FLUSH_HOLD=2, mispredict pulse, brj_addr=0x0000_1040 -> if_id/id_ex flush high 2 cycles, ex_comm_flush low. Then 1 cycle pc_en=1, npc_sel=1, redirect_pc=0x1040.
- Exception with drain: d_mem_busy high 3 cycles, exception, epc=0x8000_0100 -> 3 DRAIN cycles, then 2 FLUSH cycles with all three flushes high, then npc_sel=2, redirect_pc=0x8000_0100.
- Preemption/priority: mispredict then exception in first FLUSH cycle -> DRAIN, final npc_sel=2. Same-cycle exception+mispredict+intr -> PRIV path, intr_taken=0.
- Perf (OOO_HAZARD_PERF_EN): 5 stalled RUN cycles + 2 recoveries -> stall_cnt=5, flush_cnt=2. Preload near saturation -> holds 0xFFFF_FFFF.
